io_uart_tx: RTL and testbench

Byte-serial transmitter on the downstream side of the processor's 8-bit memory-mapped output port at 0x800. A store to the port presents one byte with a one-cycle write strobe (port-select AND MemWrite). The block buffers the byte in a small FIFO and serializes it as 8N1 UART frames on a single line. A status byte is returned for the input-port read mux, so firmware can poll for FIFO full or transmitter busy.

---
 rtl/io_uart_pkg.sv | 16 +
 rtl/io_fifo.sv | 54 +++++
 rtl/io_uart_tx.sv | 149 ++++++++++++++
 tb/tb_io_uart_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared state encoding and status bit positions for the UART transmitter
package io_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - power-of-two FIFO with combinational head, occupancy count and full/empty flags
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - 8N1 serializer behind the output port, with FIFO and pollable status byte
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic [7:0] status
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    status_q, status_d;

  logic          push, pop, baud_end;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_d;

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  // tx_d is derived from the next state so the line flop changes exactly at bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Status is registered, so it is built from the post-edge FIFO occupancy and FSM state.
  always_comb begin
    push     = wr_en && (!fifo_full || pop);
    ovf_d    = ovf_q || (wr_en && fifo_full && !pop);
    count_d  = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    status_d = 8'h00;
    status_d[STAT_FULL]  = (count_d == CW'(FIFO_DEPTH));
    status_d[STAT_EMPTY] = (count_d == '0);
    status_d[STAT_BUSY]  = (state_d != IDLE);
    status_d[STAT_OVF]   = ovf_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      status_q <= 8'h02;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
    end
  end

  assign tx     = tx_q;
  assign status = status_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed bench for io_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx;
  logic [7:0] status;

  int n_checks = 0;
  int n_pass   = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .tx      (tx),
    .status  (status)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Line receiver: mid-bit sampling of each frame, starting at the first low sample.
  always begin : rx_mon
    logic [7:0] b;
    @(negedge clk);
    if (rx_en && !reset && tx === 1'b0) begin
      repeat (CPB + CPB/2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        b[j] = tx;
        if (j < 7) repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
      check_val("rx_stop", tx, 1'b1);
      rx_q.push_back(b);
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int s = i / CPB;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return b[s-1];
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // First sample is taken at the current negedge, which must be the first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input logic [7:0] stat0);
    for (int i = 0; i < 10*CPB; i++) begin
      if (i > 0) @(negedge clk);
      check_val($sformatf("frame_%02h_s%0d", b, i), tx, frame_bit(b, i));
      if (i == 0) check_val($sformatf("frame_%02h_status", b), status, stat0);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rx_count", rx_q.size(), n);
  endtask

  initial begin
    int bad;
    logic [7:0] exp4 [5];
    logic [7:0] exp5 [6];
    exp4 = '{8'h11, 8'h21, 8'h32, 8'h43, 8'h54};
    exp5 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};

    // 1: reset
    repeat (3) begin
      @(negedge clk);
      check_val("t1_rst_tx", tx, 1'b1);
      check_val("t1_rst_status", status, 8'h02);
    end
    reset = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || status !== 8'h02) bad++;
    end
    check_val("t1_quiet", bad, 0);

    // 2: single byte
    write_byte(8'hA5);
    check_val("t2_tx_before", tx, 1'b1);
    check_val("t2_queued", status, 8'h00);
    @(negedge clk);
    check_frame(8'hA5, 8'h06);
    @(negedge clk);
    check_val("t2_idle_tx", tx, 1'b1);
    check_val("t2_idle_status", status, 8'h02);

    // 3: back-to-back frames
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk); wr_data = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    check_frame(8'h00, 8'h04);
    check_val("t3_empty_late", status, 8'h04);
    @(negedge clk);
    check_frame(8'hFF, 8'h06);
    @(negedge clk);
    check_val("t3_done", status, 8'h02);

    // 4: overflow
    rx_q.delete();
    rx_en = 1'b1;
    write_byte(8'h11);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = exp4[j];
    end
    @(negedge clk); wr_data = 8'h65;
    @(negedge clk); wr_en = 1'b0;
    check_val("t4_full_ovf", status, 8'h0D);
    wait_rx(5, 400);
    repeat (60) @(negedge clk);
    check_val("t4_no_extra", rx_q.size(), 5);
    for (int j = 0; j < 5 && j < rx_q.size(); j++)
      check_val($sformatf("t4_byte%0d", j), rx_q[j], exp4[j]);
    check_val("t4_ovf_sticky", status, 8'h0A);
    rx_en = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_val("t4_ovf_cleared", status, 8'h02);
    reset = 1'b0;

    // 5: write into a full FIFO on the pop edge
    rx_q.delete();
    rx_en = 1'b1;
    write_byte(8'hC0);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = exp5[j];
    end
    @(negedge clk); wr_en = 1'b0;
    check_val("t5_full", status, 8'h05);
    repeat (35) @(negedge clk);
    check_val("t5_full_pre_pop", status, 8'h05);
    wr_en = 1'b1; wr_data = 8'hC5;
    @(negedge clk); wr_en = 1'b0;
    check_val("t5_accepted", status, 8'h05);
    wait_rx(6, 500);
    repeat (60) @(negedge clk);
    for (int j = 0; j < 6 && j < rx_q.size(); j++)
      check_val($sformatf("t5_byte%0d", j), rx_q[j], exp5[j]);
    check_val("t5_done", status, 8'h02);
    rx_en = 1'b0;

    // 6: asynchronous reset during DATA bit 3
    write_byte(8'hA5);
    write_byte(8'h77);
    repeat (16) @(negedge clk);
    check_val("t6_bit3", tx, 1'b0);
    check_val("t6_busy", status, 8'h04);
    #1 reset = 1'b1;
    #1;
    check_val("t6_async_tx", tx, 1'b1);
    check_val("t6_async_status", status, 8'h02);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || status !== 8'h02) bad++;
    end
    check_val("t6_flushed", bad, 0);
    write_byte(8'h3C);
    @(negedge clk);
    check_frame(8'h3C, 8'h06);
    @(negedge clk);
    check_val("t6_done", status, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
